// File: rtl/exc_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exc_ctrl_if : pipeline/CP0 bundle between the MEM stage and exc_ctrl        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
interface exc_ctrl_if;
  logic        stall;
  logic        mem_valid;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_adel_if;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_sys;
  logic        exc_bp;
  logic        exc_adel_d;
  logic        exc_ades;
  logic        eret_m;
  logic [31:0] cause_in;
  logic [31:0] status_in;
  logic [31:0] epc_in;
  logic        exception_abort;
  logic [4:0]  exception_code;
  logic        bd_p;
  logic        epc_we;
  logic [31:0] epc_data;
  logic        exl_set;
  logic        exl_clr;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output stall, mem_valid, pc_m, bd_m,
    output exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades,
    output eret_m, cause_in, status_in, epc_in,
    input  exception_abort, exception_code, bd_p, epc_we, epc_data,
    input  exl_set, exl_clr, flush, redirect_valid, redirect_pc
  );

  modport slave (
    input  stall, mem_valid, pc_m, bd_m,
    input  exc_adel_if, exc_ri, exc_ov, exc_sys, exc_bp, exc_adel_d, exc_ades,
    input  eret_m, cause_in, status_in, epc_in,
    output exception_abort, exception_code, bd_p, epc_we, epc_data,
    output exl_set, exl_clr, flush, redirect_valid, redirect_pc
  );
endinterface
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | exc_ctrl : MEM-stage exception/interrupt prioritisation, entry and ERET     |
// |            sequencing. Optional EXC_IRQ_SYNC_EN adds a 2-flop irq sync.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  wire logic    clk,
  input  wire logic    rst,
  exc_ctrl_if.slave    bus
);

  localparam logic [3:0] c_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAP  = 2'd1,
    ST_RET   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [4:0]  r_code;
  logic        r_bd;
  logic [31:0] r_epc;
  logic [31:0] r_ret_pc;

  logic        w_int_raw;
  logic        w_int;
  logic        w_exc_any;
  logic [4:0]  w_exc_code;
  logic        w_capture;
  logic [31:0] w_epc;

  logic        w_abort;
  logic [4:0]  w_code_o;
  logic        w_bd_o;
  logic        w_epc_we;
  logic [31:0] w_epc_o;
  logic        w_exl_set;
  logic        w_exl_clr;
  logic        w_flush;
  logic        w_redir;
  logic [31:0] w_redir_pc;

  logic        w_unused;
  assign w_unused = ^{bus.cause_in[31:16], bus.cause_in[7:0],
                      bus.status_in[31:16], bus.status_in[7:2]};

  assign w_int_raw = bus.status_in[0] & ~bus.status_in[1]
                   & (|(bus.cause_in[15:8] & bus.status_in[15:8]));

`ifdef EXC_IRQ_SYNC_EN
  logic r_int_s1;
  logic r_int_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_s1 <= 1'b0;
      r_int_s2 <= 1'b0;
    end else begin
      r_int_s1 <= w_int_raw;
      r_int_s2 <= r_int_s1;
    end
  end

  assign w_int = r_int_s2;
`else
  assign w_int = w_int_raw;
`endif

  // Fixed priority: the first matching source supplies the ExcCode.
  always_comb begin
    w_exc_any  = 1'b1;
    w_exc_code = 5'd0;
    if (w_int)                 w_exc_code = 5'd0;
    else if (bus.exc_adel_if)  w_exc_code = 5'd4;
    else if (bus.exc_ri)       w_exc_code = 5'd10;
    else if (bus.exc_ov)       w_exc_code = 5'd12;
    else if (bus.exc_sys)      w_exc_code = 5'd8;
    else if (bus.exc_bp)       w_exc_code = 5'd9;
    else if (bus.exc_adel_d)   w_exc_code = 5'd4;
    else if (bus.exc_ades)     w_exc_code = 5'd5;
    else                       w_exc_any  = 1'b0;
  end

  assign w_capture = (r_state == ST_IDLE) & bus.mem_valid & ~bus.stall;
  assign w_epc     = bus.bd_m ? (bus.pc_m - 32'd4) : bus.pc_m;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_code   <= 5'd0;
      r_bd     <= 1'b0;
      r_epc    <= 32'd0;
      r_ret_pc <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture && w_exc_any) begin
        r_code <= w_exc_code;
        r_bd   <= bus.bd_m;
        r_epc  <= w_epc;
      end else if (w_capture && bus.eret_m) begin
        r_ret_pc <= bus.epc_in;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_abort     = 1'b0;
    w_code_o    = 5'd0;
    w_bd_o      = 1'b0;
    w_epc_we    = 1'b0;
    w_epc_o     = 32'd0;
    w_exl_set   = 1'b0;
    w_exl_clr   = 1'b0;
    w_flush     = 1'b0;
    w_redir     = 1'b0;
    w_redir_pc  = 32'd0;
    case (r_state)
      ST_IDLE: begin
        // An exception takes precedence over a simultaneous ERET.
        if (w_capture && w_exc_any)      w_state_nxt = ST_TRAP;
        else if (w_capture && bus.eret_m) w_state_nxt = ST_RET;
      end
      ST_TRAP: begin
        w_abort     = 1'b1;
        w_code_o    = r_code;
        w_bd_o      = r_bd;
        w_epc_we    = 1'b1;
        w_epc_o     = r_epc;
        w_exl_set   = 1'b1;
        w_flush     = 1'b1;
        w_redir     = 1'b1;
        w_redir_pc  = EXC_VECTOR;
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = c_FLUSH_LOAD;
      end
      ST_RET: begin
        w_exl_clr   = 1'b1;
        w_flush     = 1'b1;
        w_redir     = 1'b1;
        w_redir_pc  = r_ret_pc;
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = c_FLUSH_LOAD;
      end
      default: begin
        w_flush = 1'b1;
        if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
    endcase
  end

  assign bus.exception_abort = w_abort;
  assign bus.exception_code  = w_code_o;
  assign bus.bd_p            = w_bd_o;
  assign bus.epc_we          = w_epc_we;
  assign bus.epc_data        = w_epc_o;
  assign bus.exl_set         = w_exl_set;
  assign bus.exl_clr         = w_exl_clr;
  assign bus.flush           = w_flush;
  assign bus.redirect_valid  = w_redir;
  assign bus.redirect_pc     = w_redir_pc;

endmodule
`default_nettype wire
